time_keeper: RTL and testbench
==============================

# time_keeper

Parametrised time-of-day counter for the watch chip, successor to the fixed 24-hour seconds/minutes/hours counter. It runs entirely in the `clk` domain and derives the 1 s tick from either an internal prescaler or an external tick input. It synchronises and edge-detects the user adjust buttons and supports a parallel time load. It provides 24 h and 12 h (AM/PM) views plus BCD digits for the display driver.

## Interface
- `TICK_DIV`, 32768: `clk` cycles per second for the internal prescaler, >= 2.
- `EXT_TICK`, 0: 1 = seconds advance on rising edges of `tick_in`; 0 = seconds advance from the internal prescaler.
- `clk` in 1: the single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `tick_in` in 1: asynchronous 1 Hz source, used only when `EXT_TICK`=1.
- `run` in 1: 1 = timekeeping advances; 0 = prescaler and time frozen, adjust/load still act.
- `mode_12h` in 1: selects the `disp_hours`/`pm` view only; internal count is always 0–23.
- `min_inc`, `min_dec`, `hour_inc`, `hour_dec` in 1 each: asynchronous button levels.
- `load` in 1: synchronous one-cycle load strobe.
- `load_hours` in 5, `load_minutes` in 6, `load_seconds` in 6: load values.
- `seconds` out 6, `minutes` out 6, `hours` out 5: binary time, hours 0–23.
- `disp_hours` out 5: 0–23 when `mode_12h`=0; 1–12 when `mode_12h`=1.
- `pm` out 1: 1 when `hours` >= 12, regardless of mode.
- `bcd_time` out 24: {hour tens, hour units, min tens, min units, sec tens, sec units}, 4 bits each, built from `disp_hours`.
- `sec_pulse` out 1: one-cycle pulse on every seconds advance.
- `day_wrap` out 1: one-cycle pulse when 23:59:59 advances to 00:00:00.
- `load_err` out 1: one-cycle pulse when a load is rejected.

## Operation
- **Reset** (`reset_n`=0, asynchronous): all time fields, prescaler, synchroniser flops, edge registers and the pending-tick flag clear to 0. Outputs become 00:00:00, `disp_hours`=12 if `mode_12h` else 0, `pm`=0, all pulses 0.
- **Input conditioning**: `tick_in` and the four buttons each pass through a 2-flop synchroniser, then a rising-edge detector. Button levels never act; only edges do.
- **Tick source**:
  - Internal: the prescaler counts 0..`TICK_DIV`-1 while `run`=1 and raises a tick on the cycle it reaches `TICK_DIV`-1, then wraps to 0.
  - External: a tick is raised on each synchronised `tick_in` rise while `run`=1.
- **Seconds advance**: seconds 59→0 carries into minutes; minutes 59→0 carries into hours; hours 23→0 asserts `day_wrap`.
- **Per-cycle priority**: load > adjust > tick.
  - **Load** with all fields in range (h<24, m<60, s<60): writes all three fields, clears the prescaler and the pending flag.
  - **Load** with any field out of range: no field changes; `load_err` pulses.
  - **Adjust**: changes minutes mod 60 and/or hours mod 24 with no carry between fields; seconds are untouched.
    - Simultaneous inc and dec edges on the same field cancel.
    - Minute and hour adjusts in the same cycle both apply.
  - **Tick coinciding with load**: the tick is discarded.
  - **Tick coinciding with adjust**: the pending flag is set and the advance applies on the next cycle with no load or adjust, so no second is lost.
- **12 h view** (combinational from `hours`): 0→12 AM, 1–11→AM, 12→12 PM, 13–23→1–11 PM.

## Timing
- Button or `tick_in` rise sampled at `clk` edge k → field updates at edge k+3; `sec_pulse` is high in the cycle after k+3.
- Internal tick: the first advance after reset or load occurs exactly `TICK_DIV` cycles later; thereafter one advance every `TICK_DIV` cycles.
- `load` at edge k → fields valid after edge k; `load_err` high for the cycle after edge k.
- Deferred tick applies at most one cycle late per blocking cycle; consecutive adjust cycles keep deferring it, and only one pending tick is stored.
- All time outputs are registered. `disp_hours`, `pm` and `bcd_time` are combinational from the registers, with zero added latency.
- Reset deasserted mid-operation: counting resumes from 00:00:00 on the first qualifying tick.

## Structure
- Shared package `watch_pkg` holds:
  - constants `SEC_MAX`=59, `MIN_MAX`=59, `HOUR_MAX`=23;
  - field widths 6/6/5;
  - the `bcd_time` digit-order localparams.
- Sub-module `tk_sync_edge`: 2-flop synchroniser plus rising-edge detector, instanced five times.
- Binary-to-BCD conversion for 0–59 stays in the top as a function.

## Test plan
- `TICK_DIV`=4, load 23:59:58, `run`=1 → 23:59:59 after 4 cycles, 00:00:00 after 8 cycles with `day_wrap` pulsed once.
- Time 10:00:00, pulse `min_dec` → 10:59:00 with hours unchanged; pulse `hour_inc` twice from 23 → 01.
- `min_inc` and `min_dec` rising together at 10:30 → minutes stay 30; add `hour_inc` in the same cycle → 11:30.
- Adjust edge aligned with the internal tick at 10:30:15 → 10:31:15 then 10:31:16 one cycle later; after `TICK_DIV` cycles the total seconds advanced equals the number of ticks.
- Load 24:00:00 → `load_err` pulses and time is unchanged; load 13:05:09 with `mode_12h`=1 → `disp_hours`=1, `pm`=1, `bcd_time`=0x010509.
- Assert `reset_n`=0 mid-count asynchronously → all outputs 0 immediately; `run`=0 for 100 cycles → time frozen while buttons still adjust.

Source files
------------

// File: rtl/watch_pkg.sv
// watch_pkg -- shared time-of-day constants, field widths and bcd_time digit layout.
`default_nettype none

package watch_pkg;

  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

  localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

  // LSB position of each 4-bit digit inside bcd_time
  localparam int BCD_HOUR_TENS  = 20;
  localparam int BCD_HOUR_UNITS = 16;
  localparam int BCD_MIN_TENS   = 12;
  localparam int BCD_MIN_UNITS  = 8;
  localparam int BCD_SEC_TENS   = 4;
  localparam int BCD_SEC_UNITS  = 0;

endpackage

`default_nettype wire

// File: rtl/tk_sync_edge.sv
// tk_sync_edge -- 2-flop synchroniser followed by a registered rising-edge pulse.
`default_nettype none

module tk_sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic rise
);

  // [0],[1] synchronise; [2] holds the previous synchronised level
  logic [2:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 3'b000;
      rise   <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], din};
      rise   <= sync_q[1] & ~sync_q[2];
    end
  end

endmodule

`default_nettype wire

// File: rtl/time_keeper.sv
// time_keeper -- 24 h time-of-day counter with adjust buttons, parallel load and 12 h / BCD views.
`default_nettype none

module time_keeper
  import watch_pkg::*;
#(
  parameter int unsigned TICK_DIV = 32768,
  parameter int unsigned EXT_TICK = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              tick_in,
  input  logic              run,
  input  logic              mode_12h,
  input  logic              min_inc,
  input  logic              min_dec,
  input  logic              hour_inc,
  input  logic              hour_dec,
  input  logic              load,
  input  logic [HOUR_W-1:0] load_hours,
  input  logic [MIN_W-1:0]  load_minutes,
  input  logic [SEC_W-1:0]  load_seconds,
  output logic [SEC_W-1:0]  seconds,
  output logic [MIN_W-1:0]  minutes,
  output logic [HOUR_W-1:0] hours,
  output logic [HOUR_W-1:0] disp_hours,
  output logic              pm,
  output logic [23:0]       bcd_time,
  output logic              sec_pulse,
  output logic              day_wrap,
  output logic              load_err
);

  localparam int PRESC_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  logic tick_rise, mi_rise, md_rise, hi_rise, hd_rise;

  tk_sync_edge u_sync_tick (.clk(clk), .reset_n(reset_n), .din(tick_in),  .rise(tick_rise));
  tk_sync_edge u_sync_minc (.clk(clk), .reset_n(reset_n), .din(min_inc),  .rise(mi_rise));
  tk_sync_edge u_sync_mdec (.clk(clk), .reset_n(reset_n), .din(min_dec),  .rise(md_rise));
  tk_sync_edge u_sync_hinc (.clk(clk), .reset_n(reset_n), .din(hour_inc), .rise(hi_rise));
  tk_sync_edge u_sync_hdec (.clk(clk), .reset_n(reset_n), .din(hour_dec), .rise(hd_rise));

  logic [PRESC_W-1:0] presc;
  logic               pending;
  logic               tick, load_ok, adjust;
  logic               min_up, min_dn, hour_up, hour_dn;

  assign tick    = run & ((EXT_TICK != 0) ? tick_rise : (presc == PRESC_LAST));
  assign load_ok = load & (load_hours <= HOUR_MAX) & (load_minutes <= MIN_MAX)
                        & (load_seconds <= SEC_MAX);
  // Opposite edges on one field cancel and do not count as an adjust
  assign min_up  = mi_rise & ~md_rise;
  assign min_dn  = md_rise & ~mi_rise;
  assign hour_up = hi_rise & ~hd_rise;
  assign hour_dn = hd_rise & ~hi_rise;
  assign adjust  = min_up | min_dn | hour_up | hour_dn;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
    end else if (load_ok) begin
      presc <= '0;
    end else if (run) begin
      presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seconds   <= '0;
      minutes   <= '0;
      hours     <= '0;
      pending   <= 1'b0;
      sec_pulse <= 1'b0;
      day_wrap  <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      sec_pulse <= 1'b0;
      day_wrap  <= 1'b0;
      load_err  <= load & ~load_ok;
      if (load_ok) begin
        seconds <= load_seconds;
        minutes <= load_minutes;
        hours   <= load_hours;
        pending <= 1'b0;
      end else if (adjust) begin
        if (min_up)       minutes <= (minutes == MIN_MAX) ? '0 : minutes + 1'b1;
        else if (min_dn)  minutes <= (minutes == '0) ? MIN_MAX : minutes - 1'b1;
        if (hour_up)      hours   <= (hours == HOUR_MAX) ? '0 : hours + 1'b1;
        else if (hour_dn) hours   <= (hours == '0) ? HOUR_MAX : hours - 1'b1;
        pending <= pending | tick;
      end else if (tick || pending) begin
        pending   <= 1'b0;
        sec_pulse <= 1'b1;
        if (seconds != SEC_MAX) begin
          seconds <= seconds + 1'b1;
        end else begin
          seconds <= '0;
          if (minutes != MIN_MAX) begin
            minutes <= minutes + 1'b1;
          end else begin
            minutes <= '0;
            if (hours != HOUR_MAX) begin
              hours <= hours + 1'b1;
            end else begin
              hours    <= '0;
              day_wrap <= 1'b1;
            end
          end
        end
      end
    end
  end

  always_comb begin
    disp_hours = hours;
    if (mode_12h) begin
      if (hours == '0)             disp_hours = 5'd12;
      else if (hours > 5'd12)      disp_hours = hours - 5'd12;
    end
  end

  assign pm = (hours >= 5'd12);

  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [3:0] tens;
    tens = 4'(v / 6'd10);
    return {tens, 4'(v - 6'(tens) * 6'd10)};
  endfunction

  logic [7:0] bcd_h, bcd_m, bcd_s;

  assign bcd_h = to_bcd({1'b0, disp_hours});
  assign bcd_m = to_bcd(minutes);
  assign bcd_s = to_bcd(seconds);

  always_comb begin
    bcd_time = '0;
    bcd_time[BCD_HOUR_TENS  +: 4] = bcd_h[7:4];
    bcd_time[BCD_HOUR_UNITS +: 4] = bcd_h[3:0];
    bcd_time[BCD_MIN_TENS   +: 4] = bcd_m[7:4];
    bcd_time[BCD_MIN_UNITS  +: 4] = bcd_m[3:0];
    bcd_time[BCD_SEC_TENS   +: 4] = bcd_s[7:4];
    bcd_time[BCD_SEC_UNITS  +: 4] = bcd_s[3:0];
  end

endmodule

`default_nettype wire

// File: tb/tb_time_keeper.sv
// tb_time_keeper -- directed stimulus with a seconds-of-day reference model checked every cycle.
`default_nettype none
`timescale 1ns/1ps

module tb_time_keeper;

  localparam int TD = 4;

  logic        clk = 1'b0, reset_n = 1'b1, tick_in = 1'b0, run = 1'b0, mode_12h = 1'b0;
  logic        min_inc = 1'b0, min_dec = 1'b0, hour_inc = 1'b0, hour_dec = 1'b0, load = 1'b0;
  logic [4:0]  load_hours = '0;
  logic [5:0]  load_minutes = '0, load_seconds = '0;
  logic [5:0]  seconds, minutes;
  logic [4:0]  hours, disp_hours;
  logic        pm, sec_pulse, day_wrap, load_err;
  logic [23:0] bcd_time;

  time_keeper #(.TICK_DIV(TD), .EXT_TICK(0)) dut (
    .clk(clk), .reset_n(reset_n), .tick_in(tick_in), .run(run), .mode_12h(mode_12h),
    .min_inc(min_inc), .min_dec(min_dec), .hour_inc(hour_inc), .hour_dec(hour_dec),
    .load(load), .load_hours(load_hours), .load_minutes(load_minutes),
    .load_seconds(load_seconds), .seconds(seconds), .minutes(minutes), .hours(hours),
    .disp_hours(disp_hours), .pm(pm), .bcd_time(bcd_time), .sec_pulse(sec_pulse),
    .day_wrap(day_wrap), .load_err(load_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: time held as seconds of day; button edges act 3 edges after sampling
  int m_t, m_cnt;
  bit m_pend, m_sec, m_wrap, m_err;
  bit [3:0] h_mi, h_md, h_hi, h_hd;

  always @(posedge clk or negedge reset_n) begin
    int hh, mm, ss;
    bit mu, md, hu, hd, tk, ok;
    if (!reset_n) begin
      m_t = 0; m_cnt = 0; m_pend = 0; m_sec = 0; m_wrap = 0; m_err = 0;
      h_mi = '0; h_md = '0; h_hi = '0; h_hd = '0;
    end else begin
      mu = h_mi[2] && !h_mi[3] && !(h_md[2] && !h_md[3]);
      md = h_md[2] && !h_md[3] && !(h_mi[2] && !h_mi[3]);
      hu = h_hi[2] && !h_hi[3] && !(h_hd[2] && !h_hd[3]);
      hd = h_hd[2] && !h_hd[3] && !(h_hi[2] && !h_hi[3]);
      tk = run && (m_cnt == TD - 1);
      ok = load && (int'(load_hours) < 24) && (int'(load_minutes) < 60) && (int'(load_seconds) < 60);
      m_sec = 0; m_wrap = 0; m_err = load && !ok;
      hh = m_t / 3600; mm = (m_t / 60) % 60; ss = m_t % 60;
      if (ok) begin
        m_t = int'(load_hours) * 3600 + int'(load_minutes) * 60 + int'(load_seconds);
        m_pend = 0;
      end else if (mu || md || hu || hd) begin
        mm = (mm + (mu ? 1 : 0) + (md ? 59 : 0)) % 60;
        hh = (hh + (hu ? 1 : 0) + (hd ? 23 : 0)) % 24;
        m_t = hh * 3600 + mm * 60 + ss;
        m_pend = m_pend || tk;
      end else if (tk || m_pend) begin
        m_wrap = (m_t == 86399);
        m_t = (m_t + 1) % 86400;
        m_sec = 1; m_pend = 0;
      end
      if (ok) m_cnt = 0;
      else if (run) m_cnt = (m_cnt + 1) % TD;
      h_mi = {h_mi[2:0], min_inc};  h_md = {h_md[2:0], min_dec};
      h_hi = {h_hi[2:0], hour_inc}; h_hd = {h_hd[2:0], hour_dec};
    end
  end

  always @(posedge clk) begin
    int h, dh, eb;
    #1;
    if (reset_n && chk_en) begin
      h  = m_t / 3600;
      dh = mode_12h ? ((h % 12 == 0) ? 12 : h % 12) : h;
      eb = ((dh / 10) << 20) | ((dh % 10) << 16) | ((((m_t / 60) % 60) / 10) << 12)
         | ((((m_t / 60) % 60) % 10) << 8) | (((m_t % 60) / 10) << 4) | ((m_t % 60) % 10);
      chk("seconds", seconds, m_t % 60);
      chk("minutes", minutes, (m_t / 60) % 60);
      chk("hours", hours, h);
      chk("disp_hours", disp_hours, dh);
      chk("pm", pm, (h >= 12) ? 1 : 0);
      chk("bcd_time", bcd_time, eb);
      chk("sec_pulse", sec_pulse, m_sec);
      chk("day_wrap", day_wrap, m_wrap);
      chk("load_err", load_err, m_err);
    end
  end

  task automatic do_load(input int h, input int m, input int s);
    @(negedge clk);
    load = 1'b1; load_hours = 5'(h); load_minutes = 6'(m); load_seconds = 6'(s);
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic press(input bit mi, input bit md, input bit hi, input bit hd);
    @(negedge clk);
    min_inc = mi; min_dec = md; hour_inc = hi; hour_dec = hd;
    repeat (2) @(negedge clk);
    min_inc = 0; min_dec = 0; hour_inc = 0; hour_dec = 0;
    repeat (4) @(negedge clk);
  endtask

  task automatic chk_time(input string name, input int h, input int m, input int s);
    chk({name, ".h"}, hours, h);
    chk({name, ".m"}, minutes, m);
    chk({name, ".s"}, seconds, s);
  endtask

  initial begin
    #1 reset_n = 1'b0;
    #2;
    chk_time("reset", 0, 0, 0);
    chk("reset.disp24", disp_hours, 0);
    chk("reset.pulses", {sec_pulse, day_wrap, load_err, pm}, 0);
    mode_12h = 1'b1;
    #1 chk("reset.disp12", disp_hours, 12);
    mode_12h = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // Day wrap with TICK_DIV = 4
    run = 1'b1;
    do_load(23, 59, 58);
    chk_time("load1", 23, 59, 58);
    repeat (3) @(negedge clk);
    chk_time("pre_tick", 23, 59, 58);
    @(negedge clk);
    chk_time("tick1", 23, 59, 59);
    repeat (3) @(negedge clk);
    @(negedge clk);
    chk_time("wrap", 0, 0, 0);
    chk("wrap.day_wrap", day_wrap, 1);

    // Adjusts with timekeeping frozen
    run = 1'b0;
    do_load(10, 0, 0);
    press(0, 1, 0, 0);
    chk_time("min_dec", 10, 59, 0);
    press(1, 0, 0, 0);
    chk_time("min_inc_wrap", 10, 0, 0);
    do_load(23, 0, 0);
    press(0, 0, 1, 0);
    press(0, 0, 1, 0);
    chk_time("hour_inc2", 1, 0, 0);
    press(0, 0, 0, 1);
    press(0, 0, 0, 1);
    chk_time("hour_dec2", 23, 0, 0);
    do_load(10, 30, 0);
    press(1, 1, 0, 0);
    chk_time("cancel", 10, 30, 0);
    press(1, 1, 1, 0);
    chk_time("cancel_hinc", 11, 30, 0);

    // Adjust edge lands on the same edge as the internal tick
    run = 1'b1;
    do_load(10, 30, 15);
    min_inc = 1'b1;
    repeat (3) @(negedge clk);
    chk_time("align.pre", 10, 30, 15);
    @(negedge clk);
    chk_time("align.adj", 10, 31, 15);
    min_inc = 1'b0;
    @(negedge clk);
    chk_time("align.defer", 10, 31, 16);
    chk("align.sec_pulse", sec_pulse, 1);
    repeat (3) @(negedge clk);
    chk_time("align.next", 10, 31, 17);

    // Rejected and 12 h loads
    run = 1'b0;
    do_load(11, 30, 0);
    do_load(24, 0, 0);
    chk("bad.load_err", load_err, 1);
    chk_time("bad", 11, 30, 0);
    do_load(10, 60, 0);
    chk("bad_min.load_err", load_err, 1);
    mode_12h = 1'b1;
    do_load(13, 5, 9);
    chk("pm.disp", disp_hours, 1);
    chk("pm.pm", pm, 1);
    chk("pm.bcd", bcd_time, 24'h010509);
    do_load(12, 0, 0);
    chk("noon.bcd", bcd_time, 24'h120000);
    chk("noon.pm", pm, 1);

    // Asynchronous reset mid-count, then resume
    run = 1'b1;
    repeat (10) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk_time("async_rst", 0, 0, 0);
    chk("async_rst.bcd", bcd_time, 24'h120000);
    chk("async_rst.pm", pm, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk_time("resume", 0, 0, 1);

    // Frozen for 100 cycles while a button still adjusts
    mode_12h = 1'b0;
    run = 1'b0;
    do_load(8, 15, 30);
    repeat (47) @(negedge clk);
    press(0, 0, 1, 0);
    repeat (47) @(negedge clk);
    chk_time("frozen", 9, 15, 30);
    chk("frozen.bcd", bcd_time, 24'h091530);

    run = 1'b1;
    repeat (9) @(negedge clk);
    chk_time("run_again", 9, 15, 32);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
